delay_arbiter: RTL
==================

Name: delay_arbiter

Overview:
Round-robin arbiter that shares one `delay` register stage (N = W) among N_REQ sensor-channel requesters in the neuro_skin datapath. It selects one requester per grant, steers that requester's data onto the shared stage input and pulses the stage's `ce` for exactly one cycle. It then emits a valid/ID tag aligned with the stage output. An optional programmable gap rate-limits grants.

Parameters:
N_REQ, 4, number of requesters (2..16)
W, 8, data width per requester and width of the shared delay stage
ID_W, 2, width of channel ID; must satisfy 2^ID_W >= N_REQ
GAP_W, 4, width of the gap register

Ports:
clk  input  1  system clock, all logic on posedge
rst_n  input  1  synchronous active-low reset
en  input  1  arbitration enable; 0 blocks new grants
gap  input  GAP_W  idle cycles forced after each grant (0 = back-to-back)
req  input  N_REQ  request, one bit per channel; level, held until granted
din  input  N_REQ*W  request data, channel k at bits [k*W +: W]; stable while req[k]=1
gnt  output  N_REQ  one-hot grant, registered, high for exactly one cycle
stage_in  output  W  data to delay stage `in`; din slice of granted channel, 0 when no grant
stage_ce  output  1  to delay stage `ce`; equals OR of gnt
out_valid  output  1  high the cycle the delay stage output holds granted data
out_id  output  ID_W  channel index for the data on the stage output when out_valid=1

Behaviour:
- Reset (rst_n=0 at posedge): gnt=0, stage_ce=0, out_valid=0, out_id=0, ptr=0, gap counter=0, state=ARB. Applies mid-grant and mid-gap; any in-flight tag is dropped.
- stage_in is combinational: a mux of din by gnt. stage_ce=|gnt. All other outputs are registered.
- Priority pointer ptr (ID_W bits, range 0..N_REQ-1). The winner is the first k with eligible req[k], searching ptr, ptr+1, …, wrapping modulo N_REQ.
- Eligible req = req & ~gnt. This masks the channel granted this cycle, because its req is still high while gnt is high. A requester drops req in the cycle after gnt; a req still high after that is a new request.
- States:
  - ARB: if en=1 and any eligible req: next gnt=onehot(winner), ptr<=(winner+1) mod N_REQ. Then if gap=0 stay ARB, else load cnt<=gap and go GAP. If no eligible req or en=0: gnt<=0, stay ARB.
  - GAP: gnt<=0. cnt decrements each cycle. When cnt==1, return to ARB, so the next grant can appear on the cycle after that.
- Spacing rule: with constant requests, consecutive gnt pulses are exactly gap+1 cycles apart. gap=0 gives one grant per cycle to distinct channels.
- `gap` is sampled only at grant time. Changes during GAP do not affect the running count.
- Latency: req[k] rises in cycle T with the arbiter idle in ARB and k the winner → gnt[k]=stage_ce=1 in T+1 → the delay captures din[k] at the end of T+1 → out_valid=1 and out_id=k in T+2, with the stage output = din[k].
- out_valid<=stage_ce and out_id<=encode(gnt) every cycle (a one-cycle tag pipeline). out_id holds its last value when out_valid=0.
- en=0 in GAP: the gap continues counting; no grant is issued on return to ARB until en=1. An in-flight tag still completes.
- Simultaneous requests: strictly round-robin, so no channel waits more than N_REQ grants.
- Requests for k >= N_REQ do not exist. ptr never exceeds N_REQ-1, including at wrap.

Test Plan:
1. Reset/idle: rst_n=0 for 3 cycles, then req=0 → gnt=0, stage_ce=0, out_valid=0, out_id=0, stage_in=0 throughout.
2. Single request: gap=0, req=4'b0100, din[2]=8'hA5 held until gnt → gnt=4'b0100 one cycle later, stage_in=8'hA5. Next cycle: out_valid=1, out_id=2, delay out=8'hA5. Only one grant issued.
3. Round robin: gap=0, req=4'b1111 from reset, each channel drops req after its gnt → grants 0,1,2,3 on consecutive cycles, out_id 0,1,2,3 one cycle later. Re-raise all → order starts again at ptr=0.
4. Wrap: ptr=3 (after granting ch2), req=4'b1001 → ch3 granted, then ch0, ptr returns to 1.
5. Gap: gap=3, req=4'b0011 held continuously → gnt pulses every 4 cycles, alternating ch0/ch1. Changing gap to 1 during GAP does not shorten the current gap.
6. Reset mid-operation: rst_n=0 in the gnt cycle → next cycle gnt=0, out_valid=0, ptr=0. en=0 with req=4'b1111 → no grants until en=1.

Source files
------------

// File: rtl/delay_arbiter.sv
// delay_arbiter: round-robin arbiter feeding one shared delay stage, with a valid/ID tag and a programmable grant gap
module delay_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 8,
    parameter int ID_W  = 2,
    parameter int GAP_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [GAP_W-1:0]   gap,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] din,
    output logic [N_REQ-1:0]   gnt,
    output logic [W-1:0]       stage_in,
    output logic               stage_ce,
    output logic               out_valid,
    output logic [ID_W-1:0]    out_id
);
    localparam logic [0:0] ARB = 1'b0;
    localparam logic [0:0] GAP = 1'b1;
    logic [0:0]       state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [GAP_W-1:0] cnt_q, cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]  gid_q, gid_d;
    logic             valid_q;
    logic [ID_W-1:0]  id_q;
    logic [N_REQ-1:0] elig;
    logic             found;
    logic [ID_W-1:0]  win;
    logic [ID_W:0]    sum;
    logic [ID_W-1:0]  idx;
    // Search eligible requests starting at ptr, wrapping modulo N_REQ; the channel granted this cycle is masked
    always_comb begin
        elig  = req & ~gnt_q;
        found = 1'b0;
        win   = '0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = {1'b0, ptr_q} + (ID_W+1)'(i);
            if (sum >= (ID_W+1)'(N_REQ)) sum = sum - (ID_W+1)'(N_REQ);
            idx = sum[ID_W-1:0];
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end
    // Grant/gap state machine; gap is sampled only when a grant is issued
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = '0;
        gid_d   = gid_q;
        if (state_q == GAP) begin
            cnt_d   = cnt_q - 1'b1;
            state_d = (cnt_q == GAP_W'(1)) ? ARB : GAP;
        end else if (en && found) begin
            gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << win;
            gid_d   = win;
            ptr_d   = (win == ID_W'(N_REQ-1)) ? '0 : win + 1'b1;
            cnt_d   = gap;
            state_d = (gap == '0) ? ARB : GAP;
        end
    end
    // State registers and the one-cycle tag pipeline that lines up with the delay stage output
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ARB;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            gid_q   <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            gid_q   <= gid_d;
            valid_q <= |gnt_q;
            if (|gnt_q) id_q <= gid_q;
        end
    end
    assign gnt       = gnt_q;
    assign stage_ce  = |gnt_q;
    assign stage_in  = stage_ce ? din[gid_q*W +: W] : '0;
    assign out_valid = valid_q;
    assign out_id    = id_q;
endmodule
